// File: rtl/display_mux.sv
// Scanned driver for an N-digit common-anode, active-low 7-segment bank.
// Latches a hex word on Cargar and shows one digit per DIV-cycle slot.
module display_mux #(
    parameter int N_DIG      = 8,
    parameter int DIV        = 100000,
    parameter bit ZERO_BLANK = 1'b0
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Cargar,
    input  logic [4*N_DIG-1:0] Dato,
    input  logic [N_DIG-1:0]   Punto,
    input  logic [N_DIG-1:0]   Habilita,
    output logic [7:0]         Salida,
    output logic [N_DIG-1:0]   AN,
    output logic [3:0]         Led
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(N_DIG);

    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [4*N_DIG-1:0] sdat_q, sdat_d;
    logic [N_DIG-1:0]   sdp_q, sdp_d;
    logic [N_DIG-1:0]   sen_q, sen_d;
    logic [7:0]         salida_q, salida_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic               tick;
    logic               acc;
    logic [N_DIG-1:0]   lead_blank;
    logic [3:0]         nib;
    logic [7:0]         code;

    function automatic logic [7:0] seg_code(input logic [3:0] v);
        case (v)
            4'h0: seg_code = 8'h03;
            4'h1: seg_code = 8'h9F;
            4'h2: seg_code = 8'h25;
            4'h3: seg_code = 8'h0D;
            4'h4: seg_code = 8'h99;
            4'h5: seg_code = 8'h49;
            4'h6: seg_code = 8'h41;
            4'h7: seg_code = 8'h1F;
            4'h8: seg_code = 8'h01;
            4'h9: seg_code = 8'h19;
            4'hA: seg_code = 8'h11;
            4'hB: seg_code = 8'hC1;
            4'hC: seg_code = 8'h63;
            4'hD: seg_code = 8'h85;
            4'hE: seg_code = 8'h61;
            default: seg_code = 8'h71;
        endcase
    endfunction

    always_comb begin
        tick   = (pcnt_q == PW'(DIV - 1));
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(N_DIG - 1)) ? '0 : idx_q + IW'(1);
        end

        // Walk from the top digit down: a digit is a leading zero until some
        // enabled digit at or above it carries a nonzero nibble or a lit dp.
        acc = 1'b0;
        lead_blank = '0;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            acc = acc | (sen_q[k] & ((sdat_q[4*k +: 4] != 4'h0) | sdp_q[k]));
            lead_blank[k] = ~acc;
        end

        // The output register samples the old shadow contents for the new slot.
        nib  = sdat_q[{idx_d, 2'b00} +: 4];
        code = seg_code(nib);
        if (sdp_q[idx_d]) begin
            code[0] = 1'b0;
        end
        if (!sen_q[idx_d] || (ZERO_BLANK && (idx_d != '0) && lead_blank[idx_d])) begin
            code = 8'hFF;
        end

        salida_d = tick ? code : salida_q;
        an_d     = tick ? ~(N_DIG'(1) << idx_d) : an_q;

        sdat_d = Cargar ? Dato     : sdat_q;
        sdp_d  = Cargar ? Punto    : sdp_q;
        sen_d  = Cargar ? Habilita : sen_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pcnt_q   <= '0;
            idx_q    <= '0;
            sdat_q   <= '0;
            sdp_q    <= '0;
            sen_q    <= '0;
            salida_q <= 8'hFF;
            an_q     <= '1;
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            sdat_q   <= sdat_d;
            sdp_q    <= sdp_d;
            sen_q    <= sen_d;
            salida_q <= salida_d;
            an_q     <= an_d;
        end
    end

    assign Salida = salida_q;
    assign AN     = an_q;
    assign Led    = sdat_q[3:0];

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: two instances (zero suppression off/on) share inputs
// and are compared each cycle against a slot-level model of the display.
module tb_display_mux;

    localparam int N_DIG = 8;
    localparam int DIV   = 4;

    logic        Clk;
    logic        Rst_n;
    logic        Cargar;
    logic [31:0] Dato;
    logic [7:0]  Punto;
    logic [7:0]  Habilita;
    logic [7:0]  salida0, salida1;
    logic [7:0]  an0, an1;
    logic [3:0]  led0, led1;

    int n_tests = 0;
    int n_fail  = 0;

    display_mux #(.N_DIG(N_DIG), .DIV(DIV), .ZERO_BLANK(1'b0)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Cargar(Cargar), .Dato(Dato), .Punto(Punto),
        .Habilita(Habilita), .Salida(salida0), .AN(an0), .Led(led0)
    );

    display_mux #(.N_DIG(N_DIG), .DIV(DIV), .ZERO_BLANK(1'b1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Cargar(Cargar), .Dato(Dato), .Punto(Punto),
        .Habilita(Habilita), .Salida(salida1), .AN(an1), .Led(led1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        logic [7:0] tab [16];
        tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        return tab[v];
    endfunction

    function automatic logic [7:0] digit_seg(input int d, input logic [31:0] dat,
                                             input logic [7:0] dp, input logic [7:0] en,
                                             input bit zb);
        logic [7:0] c;
        bit lead;
        if (!en[d]) return 8'hFF;
        if (zb && d >= 1) begin
            lead = 1'b1;
            for (int j = d; j < N_DIG; j++) begin
                if (en[j] && (dat[4*j +: 4] != 4'h0 || dp[j])) lead = 1'b0;
            end
            if (lead) return 8'hFF;
        end
        c = hex_seg(dat[4*d +: 4]);
        if (dp[d]) c[0] = 1'b0;
        return c;
    endfunction

    int unsigned cyc;
    logic [31:0] m_dat;
    logic [7:0]  m_dp, m_en;
    logic [7:0]  exp_seg0, exp_seg1, exp_an;

    // Slot s (edge s*DIV after reset release) shows digit s mod N_DIG,
    // built from the shadow contents held just before that edge.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cyc      <= 0;
            m_dat    <= '0;
            m_dp     <= '0;
            m_en     <= '0;
            exp_seg0 <= 8'hFF;
            exp_seg1 <= 8'hFF;
            exp_an   <= 8'hFF;
        end else begin
            cyc <= cyc + 1;
            if ((cyc + 1) % DIV == 0) begin
                exp_an   <= ~(8'd1 << (((cyc + 1) / DIV) % N_DIG));
                exp_seg0 <= digit_seg(int'(((cyc + 1) / DIV) % N_DIG), m_dat, m_dp, m_en, 1'b0);
                exp_seg1 <= digit_seg(int'(((cyc + 1) / DIV) % N_DIG), m_dat, m_dp, m_en, 1'b1);
            end
            if (Cargar) begin
                m_dat <= Dato;
                m_dp  <= Punto;
                m_en  <= Habilita;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("seg0", salida0, exp_seg0);
        chk("seg1", salida1, exp_seg1);
        chk("an0", an0, exp_an);
        chk("an1", an1, exp_an);
        chk("led0", {4'h0, led0}, {4'h0, m_dat[3:0]});
        chk("led1", {4'h0, led1}, {4'h0, m_dat[3:0]});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge Clk);
            check_all();
        end
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
        Cargar   = 1'b1;
        Dato     = d;
        Punto    = p;
        Habilita = e;
        step(1);
        Cargar   = 1'b0;
    endtask

    // Advance to the next slot whose anode pattern equals an.
    task automatic wait_an(input logic [7:0] an);
        int n;
        n = 0;
        step(1);
        while (an0 === an && n < 80) begin
            step(1);
            n++;
        end
        while (an0 !== an && n < 80) begin
            step(1);
            n++;
        end
        chk("wait_an", an0, an);
    endtask

    initial begin
        logic [7:0] scan_tab [8];
        int k;
        int hold;
        scan_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

        Rst_n = 1'b0; Cargar = 1'b0; Dato = '0; Punto = '0; Habilita = '0;

        // Reset values held while Rst_n is low.
        repeat (3) @(negedge Clk);
        chk("rst_seg", salida0, 8'hFF);
        chk("rst_an", an0, 8'hFF);
        chk("rst_led", {4'h0, led0}, 8'h00);
        Rst_n = 1'b1;

        // Anodes idle for DIV cycles, then digit 1 is the first shown.
        step(3);
        chk("first_an_idle", an0, 8'hFF);
        step(1);
        chk("first_an", an0, 8'hFD);
        chk("first_seg_blank", salida0, 8'hFF);

        // Full scan of 76543210.
        load(32'h76543210, 8'h00, 8'hFF);
        step(N_DIG * DIV);
        for (int i = 0; i < N_DIG * DIV; i++) begin
            step(1);
            k = -1;
            for (int j = 0; j < N_DIG; j++) if (an0 === ~(8'd1 << j)) k = j;
            if (k >= 0) chk("scan_seg", salida0, scan_tab[k]);
            else chk("scan_an_onehot", an0, 8'hFE);
        end
        chk("scan_led", {4'h0, led0}, 8'h00);

        // Decimal point and a disabled digit.
        load(32'hFEDCBA98, 8'h01, 8'hFB);
        wait_an(8'hFE); chk("dp_digit0", salida0, 8'h00);
        wait_an(8'hFB); chk("disabled_digit2", salida0, 8'hFF);
        wait_an(8'h7F); chk("digit7_F", salida0, 8'h71);
        chk("dp_led", {4'h0, led0}, 8'h08);

        // Leading-zero suppression.
        load(32'h00000450, 8'h00, 8'hFF);
        step(N_DIG * DIV);
        wait_an(8'hF7); chk("zb_digit3", salida1, 8'hFF);
        chk("nozb_digit3", salida0, 8'h03);
        wait_an(8'h7F); chk("zb_digit7", salida1, 8'hFF);
        wait_an(8'hFB); chk("zb_digit2", salida1, 8'h99);
        wait_an(8'hFD); chk("zb_digit1", salida1, 8'h49);
        wait_an(8'hFE); chk("zb_digit0", salida1, 8'h03);
        load(32'h00000450, 8'h40, 8'hFF);
        step(N_DIG * DIV);
        wait_an(8'hBF); chk("zb_dp_digit6", salida1, 8'h02);
        wait_an(8'h7F); chk("zb_dp_digit7", salida1, 8'hFF);

        // Load on a tick edge: old content for this slot, new from the next.
        load(32'h11111111, 8'h00, 8'hFF);
        step(N_DIG * DIV);
        while ((cyc + 1) % DIV != 0) step(1);
        load(32'h88888888, 8'h00, 8'hFF);
        chk("race_old", salida0, 8'h9F);
        step(DIV);
        chk("race_new", salida0, 8'h01);

        // Asynchronous reset in the middle of slot 5.
        wait_an(8'hDF);
        step(1);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_seg", salida0, 8'hFF);
        chk("midrst_an", an0, 8'hFF);
        chk("midrst_led", {4'h0, led0}, 8'h00);
        step(2);
        Rst_n = 1'b1;
        step(3);
        chk("midrst_idle", an0, 8'hFF);
        step(1);
        chk("midrst_restart", an0, 8'hFD);

        // Random loads, sometimes held over several cycles.
        repeat (30) begin
            step($urandom_range(0, 12));
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                Cargar   = 1'b1;
                Dato     = $urandom;
                Punto    = 8'($urandom);
                Habilita = 8'($urandom);
                if ($urandom_range(0, 3) == 0) Dato = Dato & 32'h0000_0F0F;
                step(1);
            end
            Cargar = 1'b0;
        end
        step(N_DIG * DIV * 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
